// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - Sequential radix-2 Booth multiplier, signed or unsigned
//
// Purpose: multiplies two WIDTH-bit operands, one Booth step per clock,
// with a valid/ready handshake on both sides. One operation in flight.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands and mode valid this cycle
//   in_ready     block accepts operands this cycle (IDLE only)
//   a, b         multiplicand, multiplier (WIDTH bits)
//   signed_mode  1 = two's complement operands, 0 = unsigned
//   out_valid    p holds a valid product (DONE only)
//   out_ready    consumer takes p this cycle
//   p            product (2*WIDTH bits), held stable in DONE
//   busy         high while iterating (RUN only)

module booth_mult_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    // Operands are extended by one bit so unsigned values become
    // non-negative signed values and a single signed Booth datapath
    // serves both modes.
    localparam int XW = WIDTH + 1;
    // One extra guard bit so add/subtract cannot overflow before the shift.
    localparam int AW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [XW-1:0]     mcand;
    logic [XW-1:0]     q;
    logic              q_m1;
    logic [AW-1:0]     acc;
    logic [CNT_W-1:0]  cnt;

    logic [AW-1:0]       mcand_ext;
    logic [AW-1:0]       sum;
    logic [AW-1:0]       acc_nxt;
    logic [XW-1:0]       q_nxt;
    logic [2*WIDTH-1:0]  prod_nxt;

    assign mcand_ext = {mcand[XW-1], mcand};

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + mcand_ext;
            2'b10:   sum = acc - mcand_ext;
            default: sum = acc;
        endcase
    end

    // Arithmetic right shift of {sum, q, q_m1}; q_m1 picks up q[0] below.
    assign acc_nxt  = {sum[AW-1], sum[AW-1:1]};
    assign q_nxt    = {sum[0], q[XW-1:1]};
    // Full product sits in {acc[XW-1:0], q}; keep its low 2*WIDTH bits.
    assign prod_nxt = {acc_nxt[WIDTH-2:0], q_nxt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            acc       <= '0;
            cnt       <= '0;
            q_m1      <= 1'b0;
            mcand     <= '0;
            q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
                        q        <= signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
                        acc      <= '0;
                        q_m1     <= 1'b0;
                        cnt      <= CNT_W'(WIDTH + 1);
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    q    <= q_nxt;
                    q_m1 <= q[0];
                    cnt  <= cnt - 1'b1;
                    // Last step: publish the product in the same edge so
                    // out_valid rises exactly WIDTH+1 edges after accept.
                    if (cnt == CNT_W'(1)) begin
                        p         <= prod_nxt;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
